// File: rtl/vacc_sched.sv
// Vector accumulator sequencer: aligns to sync_in, triggers the accumulator on a
// vector boundary, detects end of drain and presents dump metadata over valid/ready.
module vacc_sched #(
  parameter int unsigned VECTOR_WIDTH  = 11,
  parameter int unsigned ACCUMULATIONS = 1048576,
  parameter int unsigned SEQ_WIDTH     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce,
  input  logic                    sync_in,
  input  logic                    arm,
  input  logic                    abort,
  input  logic                    continuous,
  input  logic                    vacc_we,
  input  logic [VECTOR_WIDTH-1:0] vacc_addr,
  input  logic                    dump_ready,
  output logic                    vacc_trig,
  output logic                    vacc_rst,
  output logic                    dump_valid,
  output logic [SEQ_WIDTH-1:0]    dump_seq,
  output logic [63:0]             dump_spectrum,
  output logic                    busy,
  output logic                    overrun,
  output logic [15:0]             drop_count,
  output logic                    timeout_err
);

  localparam logic [63:0]       WD_LIMIT = 64'(ACCUMULATIONS + 32'd4) << VECTOR_WIDTH;
  localparam int unsigned       WD_W     = 32'($clog2(WD_LIMIT));
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(WD_LIMIT - 64'd1);

  typedef enum logic [1:0] {IDLE, WAIT_SYNC, WAIT_BOUND, ACCUM} state_t;

  state_t                  state, state_nxt;
  logic                    synced;
  logic [VECTOR_WIDTH-1:0] pos_cnt;
  logic [63:0]             spec_cnt;
  logic [SEQ_WIDTH-1:0]    seq_cnt, seq_cnt_nxt;
  logic [WD_W-1:0]         wd_cnt, wd_cnt_nxt;
  logic                    cont_q, cont_q_nxt;
  logic [63:0]             pend_spec, pend_spec_nxt;

  logic                    trig_nxt, vrst_nxt, valid_nxt, ovr_nxt, tmo_nxt;
  logic [SEQ_WIDTH-1:0]    dseq_nxt;
  logic [63:0]             dspec_nxt;
  logic [15:0]             drop_nxt;

  logic boundary_c, accept_c, drain_done_c;

  assign boundary_c   = ce && !sync_in && (pos_cnt == '1);
  assign accept_c     = dump_valid && dump_ready;
  assign drain_done_c = ce && vacc_we && (vacc_addr == '1);

  // Vector position and spectrum counters run regardless of the sequencer state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      synced   <= 1'b0;
      pos_cnt  <= '0;
      spec_cnt <= '0;
    end else if (ce) begin
      if (sync_in) begin
        synced  <= 1'b1;
        pos_cnt <= VECTOR_WIDTH'(1);
      end else begin
        pos_cnt <= pos_cnt + VECTOR_WIDTH'(1);
      end
      if (boundary_c) spec_cnt <= spec_cnt + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      seq_cnt       <= '0;
      wd_cnt        <= '0;
      cont_q        <= 1'b0;
      pend_spec     <= '0;
      vacc_trig     <= 1'b0;
      vacc_rst      <= 1'b0;
      dump_valid    <= 1'b0;
      dump_seq      <= '0;
      dump_spectrum <= '0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
      drop_count    <= '0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_nxt;
      seq_cnt       <= seq_cnt_nxt;
      wd_cnt        <= wd_cnt_nxt;
      cont_q        <= cont_q_nxt;
      pend_spec     <= pend_spec_nxt;
      vacc_trig     <= trig_nxt;
      vacc_rst      <= vrst_nxt;
      dump_valid    <= valid_nxt;
      dump_seq      <= dseq_nxt;
      dump_spectrum <= dspec_nxt;
      busy          <= (state_nxt != IDLE);
      overrun       <= ovr_nxt;
      drop_count    <= drop_nxt;
      timeout_err   <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    seq_cnt_nxt   = seq_cnt;
    wd_cnt_nxt    = (state == ACCUM && ce) ? wd_cnt + WD_W'(1) : wd_cnt;
    cont_q_nxt    = cont_q;
    pend_spec_nxt = pend_spec;
    // Trigger holds until it has been seen on a ce cycle
    trig_nxt      = vacc_trig && !ce;
    vrst_nxt      = 1'b0;
    valid_nxt     = dump_valid && !accept_c;
    dseq_nxt      = dump_seq;
    dspec_nxt     = dump_spectrum;
    ovr_nxt       = overrun;
    drop_nxt      = drop_count;
    tmo_nxt       = timeout_err;

    case (state)
      IDLE: begin
        if (arm) begin
          cont_q_nxt = continuous;
          ovr_nxt    = 1'b0;
          drop_nxt   = '0;
          tmo_nxt    = 1'b0;
          state_nxt  = synced ? WAIT_BOUND : WAIT_SYNC;
        end
      end
      WAIT_SYNC: begin
        if (ce && sync_in) state_nxt = WAIT_BOUND;
      end
      WAIT_BOUND: begin
        if (boundary_c) begin
          trig_nxt      = 1'b1;
          pend_spec_nxt = spec_cnt + 64'd1;
          wd_cnt_nxt    = '0;
          state_nxt     = ACCUM;
        end
      end
      ACCUM: begin
        if (vacc_we && drain_done_c) begin
          // A dump still waiting on the packetizer wins over the new one
          if (!dump_valid || accept_c) begin
            valid_nxt = 1'b1;
            dseq_nxt  = seq_cnt;
            dspec_nxt = pend_spec;
          end else begin
            ovr_nxt = 1'b1;
            if (drop_count != 16'hFFFF) drop_nxt = drop_count + 16'd1;
          end
          seq_cnt_nxt = seq_cnt + SEQ_WIDTH'(1);
          state_nxt   = cont_q ? WAIT_BOUND : IDLE;
        end else if (ce && wd_cnt == WD_LAST) begin
          tmo_nxt   = 1'b1;
          vrst_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (abort) begin
      vrst_nxt  = 1'b1;
      trig_nxt  = 1'b0;
      valid_nxt = 1'b0;
      state_nxt = IDLE;
    end
  end

endmodule

// File: tb/tb_vacc_sched.sv
// Directed bench for vacc_sched with VECTOR_WIDTH=3, ACCUMULATIONS=2: a per-cycle
// vector table for the single-shot flow, then hand sequences for multi-cycle cases.
module tb_vacc_sched;

  logic        clk, rst_n, ce, sync_in, arm, abort, continuous, vacc_we, dump_ready;
  logic [2:0]  vacc_addr;
  logic        vacc_trig, vacc_rst, dump_valid, busy, overrun, timeout_err;
  logic [31:0] dump_seq;
  logic [63:0] dump_spectrum;
  logic [15:0] drop_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  vacc_sched #(.VECTOR_WIDTH(3), .ACCUMULATIONS(2), .SEQ_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .sync_in(sync_in), .arm(arm), .abort(abort),
    .continuous(continuous), .vacc_we(vacc_we), .vacc_addr(vacc_addr),
    .dump_ready(dump_ready), .vacc_trig(vacc_trig), .vacc_rst(vacc_rst),
    .dump_valid(dump_valid), .dump_seq(dump_seq), .dump_spectrum(dump_spectrum),
    .busy(busy), .overrun(overrun), .drop_count(drop_count), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs: {ce, sync, arm, we, addr, ready}; expected: all outputs packed
  typedef struct {
    logic [7:0]   ins;
    logic [117:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [7:0] iv(input logic c, input logic s, input logic a,
                                    input logic w, input logic [2:0] ad, input logic r);
    return {c, s, a, w, ad, r};
  endfunction

  function automatic logic [117:0] ev(input logic t, input logic v, input logic [31:0] sq,
                                      input logic [63:0] sp, input logic b);
    return {t, 1'b0, v, sq, sp, b, 1'b0, 16'd0, 1'b0};
  endfunction

  function automatic logic [117:0] outs();
    return {vacc_trig, vacc_rst, dump_valid, dump_seq, dump_spectrum,
            busy, overrun, drop_count, timeout_err};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ce = 1'b0; sync_in = 1'b0; arm = 1'b0; abort = 1'b0; continuous = 1'b0;
    vacc_we = 1'b0; vacc_addr = 3'd0; dump_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Reset, sync once, then arm; leaves pos_cnt at 2 in WAIT_BOUND
  task automatic setup(input logic cont);
    do_reset();
    ce = 1'b1; sync_in = 1'b1;
    step();
    sync_in = 1'b0; arm = 1'b1; continuous = cont;
    step();
    arm = 1'b0; continuous = 1'b0;
  endtask

  task automatic wait_trig(output int n);
    n = 0;
    while (vacc_trig !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("trig_seen", 128'(vacc_trig), 128'(1));
  endtask

  task automatic drain();
    vacc_we = 1'b1;
    for (int a = 0; a < 8; a++) begin
      vacc_addr = 3'(a);
      step();
    end
    vacc_we = 1'b0;
    vacc_addr = 3'd0;
  endtask

  initial begin
    int n;
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    chk("reset_outputs", 128'(outs()), 128'(0));
    rst_n = 1'b1;

    // Sync on row 7, arm on row 9, boundary on row 14, drain rows 16..23
    for (int i = 0; i < 7; i++) tbl.push_back('{iv(1,0,0,0,0,0), ev(0,0,0,0,0)});
    tbl.push_back('{iv(1,1,0,0,0,0), ev(0,0,0,0,0)});
    tbl.push_back('{iv(1,0,0,0,0,0), ev(0,0,0,0,0)});
    tbl.push_back('{iv(1,0,1,0,0,0), ev(0,0,0,0,1)});
    for (int i = 0; i < 4; i++) tbl.push_back('{iv(1,0,0,0,0,0), ev(0,0,0,0,1)});
    tbl.push_back('{iv(1,0,0,0,0,0), ev(1,0,0,0,1)});
    tbl.push_back('{iv(1,0,0,0,0,0), ev(0,0,0,0,1)});
    for (int a = 0; a < 7; a++) tbl.push_back('{iv(1,0,0,1,3'(a),0), ev(0,0,0,0,1)});
    tbl.push_back('{iv(1,0,0,1,3'd7,0), ev(0,1,0,1,0)});
    tbl.push_back('{iv(1,0,0,0,0,0), ev(0,1,0,1,0)});
    tbl.push_back('{iv(1,0,0,0,0,1), ev(0,0,0,1,0)});
    tbl.push_back('{iv(1,0,0,0,0,0), ev(0,0,0,1,0)});

    foreach (tbl[i]) begin
      {ce, sync_in, arm, vacc_we, vacc_addr, dump_ready} = tbl[i].ins;
      step();
      chk($sformatf("row%0d", i), 128'(outs()), 128'(tbl[i].exp));
    end
    clear_inputs();

    // Continuous with ready held: three dumps, each trigger on the next boundary
    setup(1'b1);
    dump_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_trig(n);
      chk($sformatf("cont_gap%0d", k), 128'(n), (k == 0) ? 128'(6) : 128'(7));
      step();
      drain();
      chk($sformatf("cont_dump%0d", k), 128'({dump_valid, dump_seq}), 128'({1'b1, 32'(k)}));
    end

    // Continuous with ready low: second completion is dropped
    setup(1'b1);
    wait_trig(n);
    step();
    drain();
    chk("hold_first", 128'({dump_valid, dump_seq, overrun}), 128'({1'b1, 32'd0, 1'b0}));
    wait_trig(n);
    step();
    drain();
    chk("drop_second", 128'({dump_valid, dump_seq, dump_spectrum, overrun, drop_count}),
        128'({1'b1, 32'd0, 64'd1, 1'b1, 16'd1}));
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_valid", 128'({vacc_rst, dump_valid, vacc_trig, busy}), 128'(4'b1000));
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk("rearm_clears", 128'({busy, overrun, drop_count}), 128'({1'b1, 1'b0, 16'd0}));

    // Watchdog: 48 ce cycles in ACCUM without a drain
    setup(1'b0);
    wait_trig(n);
    for (int i = 0; i < 47; i++) step();
    chk("wd_before", 128'({busy, timeout_err, vacc_rst}), 128'(3'b100));
    step();
    chk("wd_fire", 128'({busy, timeout_err, vacc_rst}), 128'(3'b011));
    step();
    chk("wd_after", 128'({busy, timeout_err, vacc_rst}), 128'(3'b010));

    // Abort mid-ACCUM
    setup(1'b0);
    wait_trig(n);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_accum", 128'({vacc_rst, busy, vacc_trig}), 128'(3'b100));
    step();
    chk("abort_rst_pulse", 128'({vacc_rst, busy}), 128'(2'b00));

    // Asynchronous reset mid-ACCUM, checked before the next clock edge
    setup(1'b0);
    wait_trig(n);
    chk("pre_reset", 128'({vacc_trig, busy}), 128'(2'b11));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 128'(outs()), 128'(0));
    step();
    rst_n = 1'b1;

    // ce alternating in WAIT_BOUND: trigger spans the ce-low cycle
    setup(1'b0);
    n = 0;
    while (n < 20) begin
      ce = 1'b1;
      step();
      n++;
      if (vacc_trig === 1'b1) break;
      ce = 1'b0;
      step();
    end
    chk("ce_steps_to_trig", 128'(n), 128'(6));
    ce = 1'b0;
    step();
    chk("trig_hold_ce_low", 128'(vacc_trig), 128'(1));
    ce = 1'b1;
    step();
    chk("trig_fall_ce_high", 128'(vacc_trig), 128'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
